// File: rtl/tsb_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state encoding and
// a constant-evaluable ceiling-log2 helper used to size counters and indices.
package tsb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width able to hold the value v, never less than one bit.
    function automatic int unsigned width_for(input int unsigned v);
        int unsigned w;
        w = clog2(v + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request bit at or after ptr,
// wrapping modulo N.
//   req    : request vector
//   ptr    : search start index
//   any    : at least one request set
//   index  : index of the winning request (0 when none)
//   onehot : one-hot of the winning request (0 when none)
module rr_pick
    import tsb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    // Walk N positions starting at ptr; the first hit wins.
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        any    = 1'b0;
        index  = '0;
        onehot = '0;
        j      = 0;
        jj     = '0;
        for (int i = 0; i < int'(N); i++) begin
            j = int'(ptr) + i;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                index      = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus. Drives one
// output enable at a time and inserts an all-off turnaround gap before each
// new owner drives. An owner holding the bus past MAX_HOLD cycles is
// preempted when somebody else is waiting (MAX_HOLD = 0 disables this).
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester level request
//   done     : per-requester release pulse (owner only, in OWN)
//   grant    : one-hot current owner (TURN and OWN)
//   oe       : one-hot tri-state enable (OWN only)
//   owner    : index of the granted requester, 0 when none
//   bus_idle : high while no requester is selected
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        done,
    output logic [N-1:0]        grant,
    output logic [N-1:0]        oe,
    output logic [clog2(N)-1:0] owner,
    output logic                bus_idle
);

    localparam int unsigned OW = clog2(N);
    localparam int unsigned TW = width_for(TURN_CYC - 1);
    localparam int unsigned HW = width_for(MAX_HOLD);

    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [OW-1:0] OWNER_LAST = OW'(N - 1);
    localparam bit            PREEMPT    = (MAX_HOLD != 0);

    state_t        state_q, state_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  oe_q, oe_d;
    logic [OW-1:0] owner_q, owner_d;
    logic          bus_idle_q, bus_idle_d;

    logic          pick_any_c;
    logic [OW-1:0] pick_index_c;
    logic [N-1:0]  pick_onehot_c;
    logic [OW-1:0] next_ptr_c;
    logic          others_c;
    logic          release_c;

    // Winner search for the IDLE state.
    rr_pick #(
        .N  (N),
        .IW (OW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any_c),
        .index  (pick_index_c),
        .onehot (pick_onehot_c)
    );

    // Pointer after the current owner leaves, wrapping at N-1.
    assign next_ptr_c = (owner_q == OWNER_LAST) ? '0 : OW'(owner_q + OW'(1));

    // Someone other than the owner is waiting.
    assign others_c = |(req & ~grant_q);

    // Any of the release causes collapses into a single release.
    assign release_c = done[owner_q] | ~req[owner_q] |
                       (PREEMPT && (hold_q == HOLD_LIMIT) && others_c);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        turn_d     = turn_q;
        hold_d     = hold_q;
        grant_d    = grant_q;
        oe_d       = oe_q;
        owner_d    = owner_q;
        bus_idle_d = bus_idle_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    state_d    = ST_TURN;
                    grant_d    = pick_onehot_c;
                    owner_d    = pick_index_c;
                    turn_d     = '0;
                    hold_d     = '0;
                    bus_idle_d = 1'b0;
                end
            end

            ST_TURN: begin
                // A request withdrawn before driving aborts without ever enabling.
                if (!req[owner_q]) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    oe_d       = '0;
                    owner_d    = '0;
                    ptr_d      = next_ptr_c;
                    turn_d     = '0;
                    hold_d     = '0;
                    bus_idle_d = 1'b1;
                end else if (turn_q == TURN_LAST) begin
                    state_d = ST_OWN;
                    oe_d    = grant_q;
                    // Hold count equals the number of OWN cycles seen so far.
                    hold_d  = PREEMPT ? HW'(1) : '0;
                end else begin
                    turn_d = TW'(turn_q + TW'(1));
                end
            end

            ST_OWN: begin
                if (release_c) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    oe_d       = '0;
                    owner_d    = '0;
                    ptr_d      = next_ptr_c;
                    turn_d     = '0;
                    hold_d     = '0;
                    bus_idle_d = 1'b1;
                end else if (hold_q != HOLD_LIMIT) begin
                    hold_d = HW'(hold_q + HW'(1));
                end
            end

            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                oe_d       = '0;
                owner_d    = '0;
                ptr_d      = '0;
                turn_d     = '0;
                hold_d     = '0;
                bus_idle_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops every enable at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            turn_q     <= '0;
            hold_q     <= '0;
            grant_q    <= '0;
            oe_q       <= '0;
            owner_q    <= '0;
            bus_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            turn_q     <= turn_d;
            hold_q     <= hold_d;
            grant_q    <= grant_d;
            oe_q       <= oe_d;
            owner_q    <= owner_d;
            bus_idle_q <= bus_idle_d;
        end
    end

    assign grant    = grant_q;
    assign oe       = oe_q;
    assign owner    = owner_q;
    assign bus_idle = bus_idle_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Testbench for tristate_bus_arbiter: directed scenarios followed by random
// req/done traffic, checked each cycle against a behavioural reference and
// against the bus invariants (one-hot, oe within grant, turnaround gap,
// bounded waiting).
module tb_tristate_bus_arbiter;

    localparam int N        = 4;
    localparam int TURN_CYC = 2;
    localparam int MAX_HOLD = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [N-1:0] oe;
    logic [1:0]   owner;
    logic         bus_idle;

    tristate_bus_arbiter #(
        .N        (N),
        .TURN_CYC (TURN_CYC),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .oe       (oe),
        .owner    (owner),
        .bus_idle (bus_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: current owner (-1 none), search start, cycles spent turning,
    // OWN cycles held, and whether the owner is driving.
    int m_owner;
    int m_ptr;
    int m_turn;
    int m_held;
    bit m_oe;

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_turn  = 0;
        m_held  = 0;
        m_oe    = 1'b0;
    endtask

    // One clock edge of the arbiter's rules, given the sampled inputs.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        logic [N-1:0] others;
        int k;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (r[k]) begin
                    m_owner = k;
                    m_turn  = 0;
                    m_oe    = 1'b0;
                    break;
                end
            end
        end else if (!m_oe) begin
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_turn++;
                if (m_turn == TURN_CYC) begin
                    m_oe   = 1'b1;
                    m_held = 1;
                end
            end
        end else begin
            others = r & ~onehot(m_owner);
            if (d[m_owner] || !r[m_owner] ||
                (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != '0)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_oe    = 1'b0;
            end else begin
                m_held++;
            end
        end
    endtask

    // Invariant bookkeeping.
    logic [N-1:0] prev_oe;
    logic [N-1:0] prev_grant;
    int           zero_run;
    bit           seen_oe;
    int           wait_g [N];

    task automatic track_reset();
        prev_oe    = '0;
        prev_grant = '0;
        zero_run   = 0;
        seen_oe    = 1'b0;
        for (int i = 0; i < N; i++) wait_g[i] = 0;
    endtask

    task automatic check_outputs();
        check_eq("grant", 32'(grant), 32'(onehot(m_owner)));
        check_eq("oe", 32'(oe), m_oe ? 32'(onehot(m_owner)) : 32'd0);
        check_eq("owner", 32'(owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check_eq("bus_idle", 32'(bus_idle), (m_owner < 0) ? 32'd1 : 32'd0);
        check_eq("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
        check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (oe != '0) begin
            check_eq("oe_in_grant", 32'(oe), 32'(grant));
            if (prev_oe == '0 && seen_oe)
                check_eq("turn_gap", 32'(zero_run >= 1 + TURN_CYC), 32'd1);
            seen_oe  = 1'b1;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    wait_g[i] = 0;
                end else if (req[i]) begin
                    wait_g[i]++;
                    check_eq("no_starve", 32'(wait_g[i] <= N), 32'd1);
                end
            end
        end
        for (int i = 0; i < N; i++) if (!req[i]) wait_g[i] = 0;
        prev_oe    = oe;
        prev_grant = grant;
    endtask

    // Check at the falling edge, apply inputs, advance the model on the rising edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        check_outputs();
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] d;

        rst  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        track_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_oe", 32'(oe), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_bus_idle", 32'(bus_idle), 32'd1);

        // Single requester, then done release.
        cycle(4'b0001, 4'b0000);
        #1 check_eq("single_grant", 32'(grant), 32'h1);
        repeat (4) cycle(4'b0001, 4'b0000);
        cycle(4'b0001, 4'b0001);
        #1 check_eq("single_release_oe", 32'(oe), 32'h0);
        repeat (2) cycle(4'b0000, 4'b0000);

        // Everybody requesting, owner releases with done as soon as it drives.
        repeat (30) cycle(4'b1111, m_oe ? onehot(m_owner) : 4'b0000);
        repeat (3) cycle(4'b0000, 4'b0000);

        // Sole requester keeps the bus; a second requester triggers preemption.
        repeat (12) cycle(4'b0100, 4'b0000);
        #1 check_eq("sole_keeps_oe", 32'(oe), 32'h4);
        repeat (14) cycle(4'b0101, 4'b0000);
        repeat (3) cycle(4'b0000, 4'b0000);

        // Request dropped during turnaround: abort, search resumes past it.
        cycle(4'b0010, 4'b0000);
        cycle(4'b0000, 4'b0000);
        cycle(4'b0000, 4'b0000);
        cycle(4'b0111, 4'b0000);
        #1 check_eq("abort_next_owner", 32'(owner), 32'd2);
        repeat (2) cycle(4'b0000, 4'b0000);

        // Asynchronous reset while a requester drives the bus.
        repeat (6) cycle(4'b0100, 4'b0000);
        #1 check_eq("pre_rst_oe", 32'(oe), 32'h4);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_oe", 32'(oe), 32'd0);
        check_eq("async_rst_grant", 32'(grant), 32'd0);
        check_eq("async_rst_owner", 32'(owner), 32'd0);
        #1 rst = 1'b0;
        model_reset();
        track_reset();
        cycle(4'b1000, 4'b0000);
        #1 check_eq("post_rst_owner", 32'(owner), 32'd3);
        repeat (4) cycle(4'b1000, 4'b0000);
        repeat (2) cycle(4'b0000, 4'b0000);

        // Random traffic: mostly held requests, owner done pulses, stray done noise.
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            d = '0;
            if (m_oe && $urandom_range(0, 3) == 0) d = onehot(m_owner);
            if ($urandom_range(0, 3) == 0) d = d | N'($urandom_range(0, 15));
            cycle(r, d);
        end

        @(negedge clk);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
